sw_field_resp: RTL and testbench

SW_FIELD_RESP -- requirements
Module: sw_field_resp

---
 rtl/sw_field_resp.sv | 159 +++++++++++++++
 tb/tb_sw_field_resp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_field_resp.sv
// Software-accessible register field with a two-state request/ack handshake and hardware update port.
// Optional macro FIELD_SW_ERR_EN adds sw_ack_err for writes to read-only and reads of write-only fields.

`ifndef SW_RW
`define SW_RW  0
`define SW_RO  1
`define SW_WO  2
`endif
`ifndef RD_NA
`define RD_NA  0
`define RD_CLR 1
`define RD_SET 2
`endif
`ifndef WR_W
`define WR_W   0
`define WR_1C  1
`define WR_1S  2
`define WR_1T  3
`define WR_0C  4
`define WR_0S  5
`endif

// Handshake: sw_req_vld is held by the requester until sw_ack_vld; an access is accepted
// on the edge where the FSM is IDLE and sw_req_vld=1, and sw_ack_vld is high for the
// single following cycle (ACK), during which sw_req_vld is ignored.
module sw_field_resp #(
    parameter int                 F_WIDTH    = 4,
    parameter int                 SW_TYPE    = `SW_RW,
    parameter int                 SW_ONREAD  = `RD_NA,
    parameter int                 SW_ONWRITE = `WR_W,
    parameter logic [F_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_req_vld,
    input  logic               sw_req_wr,
    input  logic [F_WIDTH-1:0] sw_req_wdata,
    input  logic [F_WIDTH-1:0] sw_req_wmask,
    output logic               sw_ack_vld,
    output logic [F_WIDTH-1:0] sw_ack_rdata,
    input  logic               hw_pulse,
    input  logic [F_WIDTH-1:0] hw_value,
    output logic [F_WIDTH-1:0] field_value,
    output logic               sw_modify
`ifdef FIELD_SW_ERR_EN
    ,
    output logic               sw_ack_err
`endif
);

    if (F_WIDTH < 1 || F_WIDTH > 32) begin : g_bad_width
        $fatal(1, "sw_field_resp: F_WIDTH %0d out of range 1..32", F_WIDTH);
    end
    if (SW_TYPE != `SW_RW && SW_TYPE != `SW_RO && SW_TYPE != `SW_WO) begin : g_bad_type
        $fatal(1, "sw_field_resp: unknown SW_TYPE code %0d", SW_TYPE);
    end
    if (SW_ONREAD != `RD_NA && SW_ONREAD != `RD_CLR && SW_ONREAD != `RD_SET) begin : g_bad_rd
        $fatal(1, "sw_field_resp: unknown SW_ONREAD code %0d", SW_ONREAD);
    end
    if (SW_ONWRITE < `WR_W || SW_ONWRITE > `WR_0S) begin : g_bad_wr
        $fatal(1, "sw_field_resp: unknown SW_ONWRITE code %0d", SW_ONWRITE);
    end

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic [F_WIDTH-1:0] wr_target;
    logic [F_WIDTH-1:0] sw_target;
    logic [F_WIDTH-1:0] affected;
    logic [F_WIDTH-1:0] base;
    logic [F_WIDTH-1:0] field_nxt;
    logic               changed;
    logic [F_WIDTH-1:0] rdata_q;
    logic               modify_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (sw_req_vld) begin
                accept    = 1'b1;
                state_nxt = ACK;
            end
            ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_target = field_value;
        case (SW_ONWRITE)
            `WR_W:   wr_target = sw_req_wdata;
            `WR_1C:  wr_target = field_value & ~sw_req_wdata;
            `WR_1S:  wr_target = field_value | sw_req_wdata;
            `WR_1T:  wr_target = field_value ^ sw_req_wdata;
            `WR_0C:  wr_target = field_value & sw_req_wdata;
            `WR_0S:  wr_target = field_value | ~sw_req_wdata;
            default: wr_target = field_value;
        endcase
    end

    // Bits touched by the accepted software access take the software value; every other
    // bit follows the hardware strobe (or holds).
    always_comb begin
        affected  = '0;
        sw_target = wr_target;
        if (accept) begin
            if (sw_req_wr) begin
                affected = (SW_TYPE == `SW_RO) ? '0 : sw_req_wmask;
            end else begin
                sw_target = (SW_ONREAD == `RD_CLR) ? '0 : '1;
                affected  = (SW_TYPE == `SW_WO || SW_ONREAD == `RD_NA) ? '0 : '1;
            end
        end
        base      = hw_pulse ? hw_value : field_value;
        field_nxt = (sw_target & affected) | (base & ~affected);
        changed   = |((sw_target ^ field_value) & affected);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_value <= RESET_VAL;
            rdata_q     <= '0;
            modify_q    <= 1'b0;
        end else begin
            field_value <= field_nxt;
            if (accept) begin
                rdata_q  <= (sw_req_wr || SW_TYPE == `SW_WO) ? '0 : field_value;
                modify_q <= changed;
            end
        end
    end

    assign sw_ack_vld   = (state == ACK);
    assign sw_ack_rdata = sw_ack_vld ? rdata_q : '0;
    assign sw_modify    = sw_ack_vld & modify_q;

`ifdef FIELD_SW_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= sw_req_wr ? (SW_TYPE == `SW_RO) : (SW_TYPE == `SW_WO);
        end
    end

    assign sw_ack_err = sw_ack_vld & err_q;
`endif

endmodule

// File: tb/tb_sw_field_resp.sv
// Bench for sw_field_resp: six differently configured fields share one request stream and are
// compared every cycle against a behavioural model, plus directed literal checks.

`ifndef SW_RW
`define SW_RW  0
`define SW_RO  1
`define SW_WO  2
`endif
`ifndef RD_NA
`define RD_NA  0
`define RD_CLR 1
`define RD_SET 2
`endif
`ifndef WR_W
`define WR_W   0
`define WR_1C  1
`define WR_1S  2
`define WR_1T  3
`define WR_0C  4
`define WR_0S  5
`endif

module tb_sw_field_resp;

    localparam int N = 6;

    function automatic int swt_of(input int i);
        case (i)
            2:       return `SW_RO;
            3:       return `SW_WO;
            default: return `SW_RW;
        endcase
    endfunction

    function automatic int rd_of(input int i);
        case (i)
            1, 3:    return `RD_CLR;
            2, 4:    return `RD_SET;
            default: return `RD_NA;
        endcase
    endfunction

    function automatic int wr_of(input int i);
        case (i)
            1:       return `WR_1C;
            2:       return `WR_1T;
            3:       return `WR_0S;
            4:       return `WR_1S;
            5:       return `WR_0C;
            default: return `WR_W;
        endcase
    endfunction

    function automatic logic [3:0] rv_of(input int i);
        case (i)
            0:       return 4'hA;
            2:       return 4'h3;
            3:       return 4'h5;
            5:       return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vld;
    logic       wr;
    logic [3:0] wdata;
    logic [3:0] wmask;
    logic       hwp;
    logic [3:0] hwv;

    logic       ack   [N];
    logic [3:0] rdata [N];
    logic [3:0] fv    [N];
    logic       mod   [N];
    logic       err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sw_field_resp #(
            .F_WIDTH    (4),
            .SW_TYPE    (swt_of(g)),
            .SW_ONREAD  (rd_of(g)),
            .SW_ONWRITE (wr_of(g)),
            .RESET_VAL  (rv_of(g))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .sw_req_vld   (vld),
            .sw_req_wr    (wr),
            .sw_req_wdata (wdata),
            .sw_req_wmask (wmask),
            .sw_ack_vld   (ack[g]),
            .sw_ack_rdata (rdata[g]),
            .hw_pulse     (hwp),
            .hw_value     (hwv),
            .field_value  (fv[g]),
            .sw_modify    (mod[g])
`ifdef FIELD_SW_ERR_EN
            ,
            .sw_ack_err   (err[g])
`endif
        );
`ifndef FIELD_SW_ERR_EN
        assign err[g] = 1'b0;
`endif
    end

    // behavioural model
    logic [3:0] m_f    [N];
    logic [3:0] e_rd   [N];
    logic       e_mod  [N];
    logic       e_err  [N];
    logic       e_ack;
    logic       ack_due;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        logic [3:0] target;
        logic [3:0] aff;
        logic       bad;
        logic       take;
        take = !rst && !ack_due && vld;
        for (int i = 0; i < N; i++) begin
            e_rd[i]  = 4'h0;
            e_mod[i] = 1'b0;
            e_err[i] = 1'b0;
            if (rst) begin
                m_f[i] = rv_of(i);
            end else if (take) begin
                if (wr) begin
                    bad = (swt_of(i) == `SW_RO);
                    case (wr_of(i))
                        `WR_W:   target = wdata;
                        `WR_1C:  target = m_f[i] & ~wdata;
                        `WR_1S:  target = m_f[i] | wdata;
                        `WR_1T:  target = m_f[i] ^ wdata;
                        `WR_0C:  target = m_f[i] & wdata;
                        default: target = m_f[i] | ~wdata;
                    endcase
                    aff = bad ? 4'h0 : wmask;
                end else begin
                    bad     = (swt_of(i) == `SW_WO);
                    e_rd[i] = bad ? 4'h0 : m_f[i];
                    target  = (rd_of(i) == `RD_CLR) ? 4'h0 : 4'hF;
                    aff     = (bad || rd_of(i) == `RD_NA) ? 4'h0 : 4'hF;
                end
`ifdef FIELD_SW_ERR_EN
                e_err[i] = bad;
`endif
                e_mod[i] = ((target ^ m_f[i]) & aff) != 4'h0;
                m_f[i]   = (target & aff) | ((hwp ? hwv : m_f[i]) & ~aff);
            end else if (hwp) begin
                m_f[i] = hwv;
            end
        end
        ack_due = take;
        e_ack   = take;
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk("ack_vld", i, 32'(ack[i]), 32'(e_ack));
            chk("ack_rdata", i, 32'(rdata[i]), 32'(e_rd[i]));
            chk("modify", i, 32'(mod[i]), 32'(e_mod[i]));
            chk("field", i, 32'(fv[i]), 32'(m_f[i]));
`ifdef FIELD_SW_ERR_EN
            chk("ack_err", i, 32'(err[i]), 32'(e_err[i]));
`endif
        end
    endtask

    // driver: apply inputs, advance model, sample at the falling edge
    task automatic step(input logic r, input logic v, input logic w, input logic [3:0] d,
                        input logic [3:0] m, input logic h, input logic [3:0] hv);
        rst = r; vld = v; wr = w; wdata = d; wmask = m; hwp = h; hwv = hv;
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic hw_load(input logic [3:0] v);
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, v);
    endtask

    task automatic read_req();
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    endtask

    logic       hold;
    logic       h_wr;
    logic [3:0] h_d;
    logic [3:0] h_m;

    initial begin
        for (int i = 0; i < N; i++) m_f[i] = 4'h0;
        ack_due = 1'b0;
        e_ack   = 1'b0;

        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        chk("rst_ack", 0, 32'(ack[0]), 32'h0);
        chk("rst_field", 0, 32'(fv[0]), 32'hA);
        chk("rst_field", 2, 32'(fv[2]), 32'h3);
        chk("rst_rdata", 0, 32'(rdata[0]), 32'h0);

        // plain read of a reset field
        read_req();
        chk("rd_ack", 0, 32'(ack[0]), 32'h1);
        chk("rd_rdata", 0, 32'(rdata[0]), 32'hA);
        chk("rd_field", 0, 32'(fv[0]), 32'hA);
        chk("rd_modify", 0, 32'(mod[0]), 32'h0);
        idle();

        // write-1-to-clear
        hw_load(4'hF);
        step(1'b0, 1'b1, 1'b1, 4'h5, 4'hF, 1'b0, 4'h0);
        chk("w1c_field", 1, 32'(fv[1]), 32'hA);
        chk("w1c_modify", 1, 32'(mod[1]), 32'h1);
        idle();

        // clear-on-read with an immediately following read
        hw_load(4'h6);
        read_req();
        chk("rclr_rdata", 1, 32'(rdata[1]), 32'h6);
        chk("rclr_field", 1, 32'(fv[1]), 32'h0);
        read_req();
        read_req();
        chk("rclr_rdata2", 1, 32'(rdata[1]), 32'h0);
        idle();

        // masked write colliding with a hardware strobe
        hw_load(4'h0);
        step(1'b0, 1'b1, 1'b1, 4'hF, 4'h3, 1'b1, 4'hC);
        chk("collide_field", 0, 32'(fv[0]), 32'hF);
        idle();

        // reset during the ack cycle
        read_req();
        step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        chk("abort_ack", 0, 32'(ack[0]), 32'h0);
        chk("abort_field", 0, 32'(fv[0]), 32'hA);
        read_req();
        chk("after_abort_ack", 0, 32'(ack[0]), 32'h1);
        chk("after_abort_rdata", 0, 32'(rdata[0]), 32'hA);
        idle();

        // write to a read-only field
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 4'h1, 4'hF, 1'b0, 4'h0);
        chk("ro_ack", 2, 32'(ack[2]), 32'h1);
        chk("ro_field", 2, 32'(fv[2]), 32'h3);
        chk("ro_rdata", 2, 32'(rdata[2]), 32'h0);
`ifdef FIELD_SW_ERR_EN
        chk("ro_err", 2, 32'(err[2]), 32'h1);
`endif
        idle();

        // randomized traffic; request is held until its ack
        hold = 1'b0; h_wr = 1'b0; h_d = 4'h0; h_m = 4'h0;
        for (int n = 0; n < 1500; n++) begin
            logic r;
            if (e_ack) hold = 1'b0;
            if (!hold && $urandom_range(0, 1) == 1) begin
                hold = 1'b1;
                h_wr = 1'($urandom_range(0, 1));
                h_d  = 4'($urandom_range(0, 15));
                h_m  = 4'($urandom_range(0, 15));
            end
            r = ($urandom_range(0, 63) == 0);
            step(r, hold, h_wr, h_d, h_m, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
